// File: rtl/lsu_mem_port.sv
// MEM-stage load/store unit: one req/ack transaction to word-wide data memory per access,
// with byte-enable/lane replication on stores and lane extraction plus extension on loads.
module lsu_mem_port #(
    parameter int AW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic [2:0]    load_type,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [31:0]   rdata,
    output logic          dm_req,
    output logic          dm_we,
    output logic [AW-1:0] dm_addr,
    output logic [3:0]    dm_be,
    output logic [31:0]   dm_wdata,
    input  logic [31:0]   dm_rdata,
    input  logic          dm_ack
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

    // Last ACCESS cycle count value before the request is abandoned
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state_r;
    logic [7:0]  cnt_r;
    logic [1:0]  lane_r;
    logic [2:0]  type_r;
    logic        rd_r;
    logic        req_legal_s;
    logic [31:0] load_val_s;

    function automatic logic is_legal(input logic rd, input logic wr,
                                      input logic [2:0] lt, input logic [1:0] a);
        logic ok;
        ok = 1'b0;
        case (lt)
            3'b111:  ok = 1'b1;
            3'b100:  ok = rd;
            3'b001:  ok = ~a[0];
            3'b101:  ok = rd & ~a[0];
            3'b010:  ok = (a == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok & (rd ^ wr);
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] lt, input logic [1:0] lane);
        logic [3:0] be;
        case (lt)
            3'b111, 3'b100: be = 4'b0001 << lane;
            3'b001, 3'b101: be = 4'b0011 << lane;
            3'b010:         be = 4'b1111;
            default:        be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] lt, input logic [31:0] d);
        logic [31:0] v;
        case (lt)
            3'b111, 3'b100: v = {4{d[7:0]}};
            3'b001, 3'b101: v = {2{d[15:0]}};
            default:        v = d;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] extract_load(input logic [2:0] lt, input logic [1:0] lane,
                                                 input logic [31:0] w);
        logic [31:0] b_sh;
        logic [31:0] h_sh;
        logic [31:0] v;
        b_sh = w >> {lane, 3'b000};
        h_sh = w >> {lane[1], 4'b0000};
        case (lt)
            3'b111:  v = {{24{b_sh[7]}}, b_sh[7:0]};
            3'b100:  v = {24'h000000, b_sh[7:0]};
            3'b001:  v = {{16{h_sh[15]}}, h_sh[15:0]};
            3'b101:  v = {16'h0000, h_sh[15:0]};
            default: v = w;
        endcase
        return v;
    endfunction

    assign req_legal_s = is_legal(mem_read, mem_write, load_type, addr[1:0]);
    assign load_val_s  = extract_load(type_r, lane_r, dm_rdata);
    // The stall must be visible in the start cycle itself, before the FSM leaves IDLE
    assign busy        = start | (state_r != IDLE);

    // Access FSM with registered bus, pulse and load-result outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= IDLE;
            cnt_r    <= 8'd0;
            lane_r   <= 2'b00;
            type_r   <= 3'b000;
            rd_r     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            rdata    <= 32'd0;
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_addr  <= '0;
            dm_be    <= 4'b0000;
            dm_wdata <= 32'd0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start && req_legal_s) begin
                        dm_req   <= 1'b1;
                        dm_we    <= mem_write;
                        dm_addr  <= {addr[AW-1:2], 2'b00};
                        dm_be    <= byte_en(load_type, addr[1:0]);
                        dm_wdata <= store_lanes(load_type, wdata);
                        lane_r   <= addr[1:0];
                        type_r   <= load_type;
                        rd_r     <= mem_read;
                        cnt_r    <= 8'd0;
                        state_r  <= ACCESS;
                    end else if (start) begin
                        err     <= 1'b1;
                        state_r <= RESP;
                    end
                end
                ACCESS: begin
                    if (dm_ack) begin
                        dm_req  <= 1'b0;
                        dm_we   <= 1'b0;
                        done    <= 1'b1;
                        cnt_r   <= 8'd0;
                        state_r <= RESP;
                        if (rd_r) begin
                            rdata <= load_val_s;
                        end
                    end else if (cnt_r == TO_LAST) begin
                        dm_req  <= 1'b0;
                        dm_we   <= 1'b0;
                        err     <= 1'b1;
                        cnt_r   <= 8'd0;
                        state_r <= RESP;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                RESP: begin
                    state_r <= IDLE;
                end
                default: begin
                    dm_req  <= 1'b0;
                    dm_we   <= 1'b0;
                    cnt_r   <= 8'd0;
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port: expected results queue up at each request and are
// popped when done/err appears; a small memory responder acks after a set wait count.
module tb_lsu_mem_port;
    localparam int AW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start, mem_read, mem_write;
    logic [2:0]    load_type;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          busy, done, err;
    logic [31:0]   rdata;
    logic          dm_req, dm_we;
    logic [AW-1:0] dm_addr;
    logic [3:0]    dm_be;
    logic [31:0]   dm_wdata, dm_rdata;
    logic          dm_ack;

    typedef struct packed {
        logic        e;
        logic [31:0] r;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    lsu_mem_port #(.AW(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .mem_read(mem_read),
        .mem_write(mem_write), .load_type(load_type), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .err(err), .rdata(rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input string what,
                         input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s.%s observed=%h expected=%h", tag, what, obs, expv);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One access from the start cycle through the cycle after its done/err pulse.
    // waits < 0 means the memory never acks.
    task automatic txn(input string tag, input logic rd, input logic wr, input logic [2:0] lt,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rw,
                       input int waits, input logic exp_err, input logic [31:0] exp_rd,
                       input logic [31:0] exp_addr, input logic [3:0] exp_be,
                       input logic [31:0] exp_wd, input int exp_req, input int exp_lat);
        int t, req_n, busy_n, lat;
        logic seen, unstable;
        logic [31:0] a0, wd0;
        logic [3:0] be0;
        logic we0;
        exp_t e;
        mem_read = rd; mem_write = wr; load_type = lt; addr = a; wdata = wd;
        dm_rdata = rw; start = 1'b1;
        exp_q.push_back('{exp_err, exp_rd});
        #1;
        check(tag, "busy_start", {31'd0, busy}, 32'd1);
        busy_n = 1; req_n = 0; seen = 1'b0; unstable = 1'b0; t = 0; lat = 0;
        a0 = '0; wd0 = '0; be0 = '0; we0 = 1'b0;
        step();
        start = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'h5A5A_5A5A; load_type = 3'b000;
        while (!seen && t < 64) begin
            t++;
            if (busy) busy_n++;
            if (dm_req) begin
                req_n++;
                if (req_n == 1) begin
                    a0 = dm_addr; be0 = dm_be; wd0 = dm_wdata; we0 = dm_we;
                    check(tag, "dm_addr", dm_addr, exp_addr);
                    check(tag, "dm_be", {28'd0, dm_be}, {28'd0, exp_be});
                    check(tag, "dm_wdata", dm_wdata, exp_wd);
                    check(tag, "dm_we", {31'd0, dm_we}, {31'd0, wr});
                end else if (dm_addr !== a0 || dm_be !== be0 || dm_wdata !== wd0 || dm_we !== we0) begin
                    unstable = 1'b1;
                end
                dm_ack = (req_n == waits + 1);
            end
            if (done || err) begin
                seen = 1'b1;
                lat = t;
                e = exp_q.pop_front();
                check(tag, "err", {31'd0, err}, {31'd0, e.e});
                check(tag, "done", {31'd0, done}, {31'd0, ~e.e});
                check(tag, "rdata", rdata, e.r);
            end
            step();
            dm_ack = 1'b0;
        end
        if (!seen) exp_q.delete();
        check(tag, "completed", {31'd0, seen}, 32'd1);
        check(tag, "req_cycles", req_n, exp_req);
        check(tag, "latency", lat, exp_lat);
        check(tag, "busy_cycles", busy_n, exp_lat + 1);
        check(tag, "bus_stable", {31'd0, unstable}, 32'd0);
        check(tag, "after", {29'd0, done, err, busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; mem_read = 1'b0; mem_write = 1'b0; load_type = 3'b000;
        addr = '0; wdata = '0; dm_rdata = '0; dm_ack = 1'b0;
        step();
        step();
        check("reset", "outs", {28'd0, busy, done, err, dm_req}, 32'd0);
        check("reset", "dm_we_be", {27'd0, dm_we, dm_be}, 32'd0);
        check("reset", "dm_addr", dm_addr, 32'd0);
        check("reset", "dm_wdata", dm_wdata, 32'd0);
        check("reset", "rdata", rdata, 32'd0);
        reset = 1'b1;
        step();

        txn("lb",   1, 0, 3'b111, 32'h1003, 32'h0, 32'h8012_3456, 2, 0, 32'hFFFF_FF80,
            32'h1000, 4'b1000, 32'h0, 3, 4);
        txn("lhu",  1, 0, 3'b101, 32'h2002, 32'h0, 32'hBEEF_1234, 0, 0, 32'h0000_BEEF,
            32'h2000, 4'b1100, 32'h0, 1, 2);
        txn("sh",   0, 1, 3'b001, 32'h3002, 32'h0000_ABCD, 32'h1111_1111, 1, 0, 32'h0000_BEEF,
            32'h3000, 4'b1100, 32'hABCD_ABCD, 2, 3);
        txn("lw_mis", 1, 0, 3'b010, 32'h4001, 32'h0, 32'h0, 0, 1, 32'h0000_BEEF,
            32'h0, 4'b0000, 32'h0, 0, 1);
        txn("lt011", 1, 0, 3'b011, 32'h4000, 32'h0, 32'h0, 0, 1, 32'h0000_BEEF,
            32'h0, 4'b0000, 32'h0, 0, 1);
        txn("sw_to", 0, 1, 3'b010, 32'h9000, 32'h1122_3344, 32'h0, -1, 1, 32'h0000_BEEF,
            32'h9000, 4'b1111, 32'h1122_3344, TO, TO + 1);
        txn("lbu",  1, 0, 3'b100, 32'h5001, 32'h0, 32'h0000_F000, 0, 0, 32'h0000_00F0,
            32'h5000, 4'b0010, 32'h0, 1, 2);
        txn("sb",   0, 1, 3'b111, 32'h6003, 32'h1234_5677, 32'h0, 0, 0, 32'h0000_00F0,
            32'h6000, 4'b1000, 32'h7777_7777, 1, 2);
        txn("lh_edge", 1, 0, 3'b001, 32'h7000, 32'h0, 32'h1234_8001, TO - 1, 0, 32'hFFFF_8001,
            32'h7000, 4'b0011, 32'h0, TO, TO + 1);
        txn("shu",  0, 1, 3'b101, 32'h7000, 32'h0, 32'h0, 0, 1, 32'hFFFF_8001,
            32'h0, 4'b0000, 32'h0, 0, 1);
        txn("rdwr", 1, 1, 3'b010, 32'h7000, 32'h0, 32'h0, 0, 1, 32'hFFFF_8001,
            32'h0, 4'b0000, 32'h0, 0, 1);

        // A stray ack while idle must not produce a response
        dm_ack = 1'b1;
        step();
        dm_ack = 1'b0;
        check("idle_ack", "outs", {29'd0, done, err, busy}, 32'd0);

        // Reset in the middle of an access aborts it with no pulse
        mem_read = 1'b1; mem_write = 1'b0; load_type = 3'b010; addr = 32'h8000; start = 1'b1;
        step();
        start = 1'b0;
        check("abort", "req_before", {31'd0, dm_req}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("abort", "req_async", {28'd0, dm_req, done, err, busy}, 32'd0);
        step();
        check("abort", "held", {29'd0, dm_req, done, err}, 32'd0);
        check("abort", "rdata", rdata, 32'd0);
        reset = 1'b1;
        step();
        txn("lw_after", 1, 0, 3'b010, 32'h8000, 32'h0, 32'hCAFE_F00D, 0, 0, 32'hCAFE_F00D,
            32'h8000, 4'b1111, 32'h0, 1, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Load/store access unit on the MEM stage of the pipeline processor.
- Consumes the 3-bit Load_Type code from the ALU controller (also used as the store width code) plus the ALU-computed address.
- Runs a req/ack transaction to word-wide data memory, generating byte enables on stores and lane extraction plus sign/zero extension on loads.
- Holds the pipeline via busy until the access completes or times out.

Parameters:
- AW, 32, address width in bits.
- TIMEOUT, 255, maximum wait cycles for dm_ack before abort (1..255, 8-bit counter).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request from MEM stage; sampled only in IDLE.
- mem_read  input  1  access is a load.
- mem_write  input  1  access is a store.
- load_type  input  3  111=LB/SB, 001=LH/SH, 010=LW/SW, 100=LBU, 101=LHU; anything else illegal.
- addr  input  AW  byte address.
- wdata  input  32  store data, LSB-justified.
- busy  output  1  access in progress; MEM stage stalls.
- done  output  1  one-cycle pulse: access completed successfully.
- err  output  1  one-cycle pulse: misaligned, illegal code, or timeout.
- rdata  output  32  extended load result; valid when done and mem_read was set; held until the next done.
- dm_req  output  1  memory request.
- dm_we  output  1  1 = write.
- dm_addr  output  AW  word-aligned address; addr with [1:0] = 00.
- dm_be  output  4  byte enables.
- dm_wdata  output  32  lane-aligned store data.
- dm_rdata  input  32  memory read word.
- dm_ack  input  1  memory completes the request this cycle.

Behaviour:
- Reset, asynchronous active-low: state IDLE; busy, done, err, dm_req, dm_we = 0; dm_be = 0; dm_addr, dm_wdata, rdata = 0; timeout counter = 0.
- States: IDLE, ACCESS, RESP.
- IDLE, start=1, illegal request: goes to RESP with err pending and no bus activity. Illegal means any of:
  - mem_read == mem_write;
  - load_type not in the legal set (LBU/LHU codes with mem_write are illegal);
  - misaligned: half with addr[0]=1, or word with addr[1:0]!=00.
- IDLE, start=1, legal request: registers dm_addr, dm_we=mem_write, dm_be, dm_wdata, lane=addr[1:0]; goes to ACCESS; dm_req=1 from the next cycle.
- IDLE, start=0: no change.
- ACCESS:
  - dm_req stays 1 with stable dm_addr, dm_be, dm_wdata, dm_we until the dm_ack cycle.
  - On dm_ack: dm_req drops the following cycle; rdata is captured from dm_rdata; go to RESP with done pending.
  - Without dm_ack the counter increments. When it reaches TIMEOUT: drop dm_req, go to RESP with err pending.
- RESP: pulses done or err for exactly one cycle, then returns to IDLE. Zero-wait ack gives done 2 cycles after start.
- busy = 1 in ACCESS and RESP, and is asserted combinationally in the start cycle; busy = 0 in IDLE otherwise.
- start while busy is ignored; the pipeline guarantees it is not issued.
- Byte enables:
  - byte: 0001 << lane;
  - half: 0011 << lane;
  - word: 1111.
- Store data:
  - byte: wdata[7:0] replicated to all 4 lanes;
  - half: wdata[15:0] replicated to both halves;
  - word: wdata unchanged.
- Load extraction:
  - byte: dm_rdata[8*lane+7 : 8*lane], sign-extended for 111, zero-extended for 100;
  - half: dm_rdata[16*lane[1]+15 : 16*lane[1]], sign-extended for 001, zero-extended for 101;
  - word: dm_rdata unchanged.
- Stores leave rdata unchanged.
- dm_ack outside ACCESS is ignored.
- Reset mid-access aborts immediately: dm_req=0 asynchronously, with no done or err pulse.

Test Plan:
- LB, addr=0x1003, dm_rdata=0x80_12_34_56, ack after 2 wait cycles -> dm_addr=0x1000, dm_be=1000 never drives a write, rdata=0xFFFFFF80, done pulses once, busy for 5 cycles.
- LHU, addr=0x2002, dm_rdata=0xBEEF_1234, zero-wait ack -> rdata=0x0000BEEF, done 2 cycles after start.
- SH, addr=0x3002, wdata=0x0000ABCD -> dm_we=1, dm_be=1100, dm_wdata=0xABCDABCD, done, rdata unchanged.
- LW, addr=0x4001 -> no dm_req, err pulses 1 cycle after start, busy for 2 cycles; repeat with load_type=011 -> same response.
- SW, dm_ack never asserted, TIMEOUT=4 -> dm_req high exactly 4 cycles then low, err pulse, return to IDLE.
- LW in ACCESS, reset asserted asynchronously -> dm_req=0 immediately, no done/err; after release, a new LW completes normally.
